// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Bundles the fetch-stage control inputs and the PC-related outputs of
// pc_fetch_unit into a single interface.
//   slave  modport : used by pc_fetch_unit (control in, PC/status out)
//   master modport : used by the driving side (controller / testbench)
// Signals:
//   en, NPCOp[1:0], Branch, imm16[15:0], imm26[25:0], ra[31:0]   (to unit)
//   PC, PC4, NPC, fault, fault_code[1:0], inst_count              (from unit)
// Optional (PC_FLOW_STATS_EN defined): taken_count, jump_count   (from unit)
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if;
  logic        en;
  logic [1:0]  NPCOp;
  logic        Branch;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] ra;

  logic [31:0] PC;
  logic [31:0] PC4;
  logic [31:0] NPC;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] inst_count;
`ifdef PC_FLOW_STATS_EN
  logic [31:0] taken_count;
  logic [31:0] jump_count;
`endif

  modport slave (
    input  en, NPCOp, Branch, imm16, imm26, ra,
`ifdef PC_FLOW_STATS_EN
    output taken_count, jump_count,
`endif
    output PC, PC4, NPC, fault, fault_code, inst_count
  );

  modport master (
    output en, NPCOp, Branch, imm16, imm26, ra,
`ifdef PC_FLOW_STATS_EN
    input  taken_count, jump_count,
`endif
    input  PC, PC4, NPC, fault, fault_code, inst_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter stage: selects the next PC (sequential, conditional
// branch, j/jal, jr), holds the architectural PC and a retired-instruction
// counter, and traps illegal fetch targets into a sticky FAULT state that
// only reset clears.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : pc_fetch_unit_if.slave (control inputs, PC / status outputs)
// Parameters:
//   RESET_PC : PC after reset
//   IM_BASE  : lowest legal fetch address
//   IM_WORDS : instruction-memory depth in words
// Optional feature macro PC_FLOW_STATS_EN: adds taken_count / jump_count.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic             clk,
  input  logic             reset,
  pc_fetch_unit_if.slave   bus
);

  // Address of the last legal instruction word.
  localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

  typedef enum logic {ST_RUN, ST_FAULT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst_count;
  logic        r_fault;
  logic [1:0]  r_fault_code;

  logic [31:0] w_pc4;
  logic [31:0] w_br_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_npc;
  logic        w_mis;
  logic        w_oor;

  assign w_pc4         = r_pc + 32'd4;
  assign w_br_target   = w_pc4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign w_jump_target = {r_pc[31:28], bus.imm26, 2'b00};

  always_comb begin
    // NOTE: default assignment first so every path drives w_npc; a missing
    // branch in combinational logic would otherwise infer a latch.
    w_npc = w_pc4;
    unique case (bus.NPCOp)
      2'd0: w_npc = w_pc4;
      2'd1: w_npc = bus.Branch ? w_br_target : w_pc4;
      2'd2: w_npc = w_jump_target;
      2'd3: w_npc = bus.ra;
      default: w_npc = w_pc4;
    endcase
  end

  assign w_mis = (w_npc[1:0] != 2'b00);
  assign w_oor = (w_npc < IM_BASE) || (w_npc > IM_LAST);

`ifdef PC_FLOW_STATS_EN
  logic [31:0] r_taken_count;
  logic [31:0] r_jump_count;
  logic        w_is_taken;
  logic        w_is_jump;

  assign w_is_taken = (bus.NPCOp == 2'd1) && bus.Branch;
  assign w_is_jump  = bus.NPCOp[1];   // NPCOp 2 (j/jal) or 3 (jr)
`endif

  // Single FSM block: the state and every registered output move together.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the pre-edge values, independent of statement order.
    if (reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_inst_count <= 32'd0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
`ifdef PC_FLOW_STATS_EN
      r_taken_count <= 32'd0;
      r_jump_count  <= 32'd0;
`endif
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (bus.en) begin
            if (w_mis || w_oor) begin
              // Misalignment wins when the target is both misaligned and
              // out of range.
              r_state      <= ST_FAULT;
              r_fault      <= 1'b1;
              r_fault_code <= w_mis ? 2'b01 : 2'b10;
            end else begin
              r_pc         <= w_npc;
              r_inst_count <= r_inst_count + 32'd1;
`ifdef PC_FLOW_STATS_EN
              if (w_is_taken) r_taken_count <= r_taken_count + 32'd1;
              if (w_is_jump)  r_jump_count  <= r_jump_count + 32'd1;
`endif
            end
          end
        end
        // FAULT is sticky: everything is frozen until reset.
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_FAULT;
      endcase
    end
  end

  assign bus.PC         = r_pc;
  assign bus.PC4        = w_pc4;
  assign bus.NPC        = w_npc;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
  assign bus.inst_count = r_inst_count;
`ifdef PC_FLOW_STATS_EN
  assign bus.taken_count = r_taken_count;
  assign bus.jump_count  = r_jump_count;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized stimulus, all compared against a behavioural model of the
// architectural PC, counter and fault status.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 4096;
  localparam logic [31:0] IM_TOP   = 32'h0000_6FFC;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .IM_BASE  (IM_BASE),
    .IM_WORDS (IM_WORDS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_fault;
  logic [1:0]  m_code;
  logic [31:0] m_taken;
  logic [31:0] m_jump;
  bit          m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [1:0] op,
                                          input logic br, input logic [15:0] i16,
                                          input logic [25:0] i26, input logic [31:0] ra);
    logic [31:0] seq;
    logic [31:0] off;
    seq = pc + 32'd4;
    off = 32'($signed(i16)) * 32'd4;
    case (op)
      2'd0:    return seq;
      2'd1:    return br ? seq + off : seq;
      2'd2:    return (pc & 32'hF000_0000) | (32'(i26) * 32'd4);
      default: return ra;
    endcase
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, update the
  // model, check registered outputs.
  task automatic step(input logic rst, input logic en, input logic [1:0] op,
                      input logic br, input logic [15:0] i16,
                      input logic [25:0] i26, input logic [31:0] ra);
    logic [31:0] npc;
    @(negedge clk);
    reset      = rst;
    bus.en     = en;
    bus.NPCOp  = op;
    bus.Branch = br;
    bus.imm16  = i16;
    bus.imm26  = i26;
    bus.ra     = ra;
    #1;
    npc = ref_npc(m_pc, op, br, i16, i26, ra);
    if (m_known) begin
      check("npc", bus.NPC, npc);
      check("pc4", bus.PC4, m_pc + 32'd4);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = 32'h0000_3000; m_cnt = 0; m_fault = 0; m_code = 2'b00;
      m_taken = 0; m_jump = 0; m_known = 1'b1;
    end else if (!m_fault && en) begin
      if (npc % 4 != 0) begin
        m_fault = 1; m_code = 2'b01;
      end else if (npc < IM_BASE || npc > IM_BASE + 4 * IM_WORDS - 4) begin
        m_fault = 1; m_code = 2'b10;
      end else begin
        m_pc  = npc;
        m_cnt = m_cnt + 1;
        if (op == 2'd1 && br) m_taken = m_taken + 1;
        if (op >= 2'd2)       m_jump  = m_jump + 1;
      end
    end
    if (m_known) begin
      check("pc", bus.PC, m_pc);
      check("fault", 32'(bus.fault), 32'(m_fault));
      check("fault_code", 32'(bus.fault_code), 32'(m_code));
      check("inst_count", bus.inst_count, m_cnt);
`ifdef PC_FLOW_STATS_EN
      check("taken_count", bus.taken_count, m_taken);
      check("jump_count", bus.jump_count, m_jump);
`endif
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_0001);
  endtask

  initial begin
    logic        r_en, r_br, r_rst;
    logic [1:0]  r_op;
    logic [15:0] r_i16;
    logic [25:0] r_i26;
    logic [31:0] r_ra;

    bus.en = 0; bus.NPCOp = 0; bus.Branch = 0;
    bus.imm16 = 0; bus.imm26 = 0; bus.ra = 0;

    // Reset state and sequential fetch
    do_reset();
    check("rst_pc", bus.PC, 32'h0000_3000);
    check("rst_count", bus.inst_count, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    check("seq_pc", bus.PC, 32'h0000_300C);
    check("seq_count", bus.inst_count, 32'd3);
    #1 check("seq_pc4", bus.PC4, 32'h0000_3010);

    // Backward branch taken / not taken from 0x3008
    do_reset();
    step(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 1, 2'd1, 1, 16'hFFFE, 26'h0, 32'h0);
    check("br_taken", bus.PC, 32'h0000_3004);
    step(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 1, 2'd1, 0, 16'hFFFE, 26'h0, 32'h0);
    check("br_not_taken", bus.PC, 32'h0000_300C);

    // jal then jr
    do_reset();
    #1 check("jal_link", bus.PC4, 32'h0000_3004);
    step(0, 1, 2'd2, 0, 16'h0, 26'h000_0C10, 32'h0);
    check("jal_pc", bus.PC, 32'h0000_3040);
    step(0, 1, 2'd3, 0, 16'h0, 26'h0, 32'h0000_3004);
    check("jr_pc", bus.PC, 32'h0000_3004);

    // Misaligned jr faults and freezes until reset
    step(0, 1, 2'd3, 0, 16'h0, 26'h0, 32'h0000_3002);
    check("mis_code", 32'(bus.fault_code), 32'd1);
    step(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    step(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    check("frozen_pc", bus.PC, 32'h0000_3004);
    do_reset();
    check("fault_clr", 32'(bus.fault), 32'd0);

    // Out-of-range jr; last legal word; sequential past the top
    step(0, 1, 2'd3, 0, 16'h0, 26'h0, 32'h0000_7000);
    check("oor_code", 32'(bus.fault_code), 32'd2);
    do_reset();
    step(0, 1, 2'd3, 0, 16'h0, 26'h0, IM_TOP);
    check("top_pc", bus.PC, IM_TOP);
    step(0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    check("top_seq_code", 32'(bus.fault_code), 32'd2);

    // Stall with an illegal target raises nothing
    do_reset();
    step(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h0000_0001);
    step(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h0000_0001);
    check("stall_fault", 32'(bus.fault), 32'd0);
    check("stall_count", bus.inst_count, 32'd0);

    // One taken branch plus one jal
    step(0, 1, 2'd1, 1, 16'h0004, 26'h0, 32'h0);
    step(0, 1, 2'd2, 0, 16'h0, 26'h000_0C10, 32'h0);
`ifdef PC_FLOW_STATS_EN
    check("stats_taken", bus.taken_count, 32'd1);
    check("stats_jump", bus.jump_count, 32'd1);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r_rst = m_fault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      r_en  = ($urandom_range(0, 9) != 0);
      r_op  = 2'($urandom_range(0, 3));
      r_br  = 1'($urandom_range(0, 1));
      r_i16 = ($urandom_range(0, 4) == 0) ? 16'($urandom)
                                          : 16'(int'($urandom_range(0, 32)) - 16);
      r_i26 = ($urandom_range(0, 9) == 0) ? 26'($urandom)
                                          : 26'(32'h0000_0C00 + $urandom_range(0, 4095));
      case ($urandom_range(0, 9))
        0:       r_ra = $urandom;
        1:       r_ra = (IM_BASE + 32'(4 * $urandom_range(0, 4095))) | 32'd1;
        2:       r_ra = IM_TOP + 32'd4;
        default: r_ra = IM_BASE + 32'(4 * $urandom_range(0, 4095));
      endcase
      step(r_rst, r_en, r_op, r_br, r_i16, r_i26, r_ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
